// File: rtl/alu_result_buffer_if.sv
// alu_result_buffer_if: producer/consumer handshake bundle for the ALU result buffer
interface alu_result_buffer_if #(parameter int op = 8, parameter int depth = 4);
  logic in_valid;
  logic in_ready;
  logic [op-1:0] y;
  logic [$clog2(op)-1:0] opcode;
  logic [$clog2(op):0] b;
  logic out_valid;
  logic out_ready;
  logic [op-1:0] out_y;
  logic [$clog2(op)-1:0] out_opcode;
  logic out_zero;
  logic out_dz;
  logic [$clog2(depth):0] count;
  modport master (
    output in_valid, y, opcode, b, out_ready,
    input in_ready, out_valid, out_y, out_opcode, out_zero, out_dz, count
  );
  modport slave (
    input in_valid, y, opcode, b, out_ready,
    output in_ready, out_valid, out_y, out_opcode, out_zero, out_dz, count
  );
endinterface

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: circular FIFO of ALU results tagged with zero/div-by-zero flags;
// define ALU_RESULT_STATS_EN to add saturating push/dz/stall statistics counters.
module alu_result_buffer #(
  parameter int op = 8,
  parameter int depth = 4
) (
  input logic clk,
  input logic rst,
`ifdef ALU_RESULT_STATS_EN
  output logic [7:0] stat_total,
  output logic [7:0] stat_dz,
  output logic [7:0] stat_full_stall,
`endif
  alu_result_buffer_if.slave bus
);
  localparam int ow = $clog2(op);
  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  logic [op-1:0] mem_y [depth];
  logic [ow-1:0] mem_op [depth];
  logic [depth-1:0] mem_zero, mem_dz;
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic [cw-1:0] count;
  logic push, pop, dz;
  always_comb begin
    bus.in_ready = count < cw'(depth);
    bus.out_valid = count != '0;
    push = bus.in_valid && bus.in_ready;
    pop = bus.out_valid && bus.out_ready;
    dz = bus.opcode == ow'(3) && bus.b == '0;
    bus.out_y = mem_y[rd_ptr];
    bus.out_opcode = mem_op[rd_ptr];
    bus.out_zero = mem_zero[rd_ptr];
    bus.out_dz = mem_dz[rd_ptr];
    bus.count = count;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + aw'(push);
      rd_ptr <= rd_ptr + aw'(pop);
      count <= count + cw'(push) - cw'(pop);
    end
  end
  // storage is deliberately not reset; head fields are don't-care while empty
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_y[wr_ptr] <= bus.y;
      mem_op[wr_ptr] <= bus.opcode;
      mem_zero[wr_ptr] <= bus.y == '0;
      mem_dz[wr_ptr] <= dz;
    end
  end
`ifdef ALU_RESULT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total <= '0;
      stat_dz <= '0;
      stat_full_stall <= '0;
    end else begin
      if (push && stat_total != 8'hff) stat_total <= stat_total + 8'd1;
      if (push && dz && stat_dz != 8'hff) stat_dz <= stat_dz + 8'd1;
      if (bus.in_valid && !bus.in_ready && stat_full_stall != 8'hff) stat_full_stall <= stat_full_stall + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: directed self-checking bench for alu_result_buffer
module tb_alu_result_buffer;
  logic clk = 0;
  logic rst = 1;
  int errors = 0;
  int checks = 0;
  logic [7:0] q [$];
`ifdef ALU_RESULT_STATS_EN
  logic [7:0] stat_total, stat_dz, stat_full_stall;
`endif
  alu_result_buffer_if #(.op(8), .depth(4)) bus ();
  alu_result_buffer #(.op(8), .depth(4)) dut (
    .clk(clk),
    .rst(rst),
`ifdef ALU_RESULT_STATS_EN
    .stat_total(stat_total),
    .stat_dz(stat_dz),
    .stat_full_stall(stat_full_stall),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] y, input logic [2:0] opc, input logic [3:0] b);
    bus.y = y;
    bus.opcode = opc;
    bus.b = b;
    bus.in_valid = 1;
    step();
    bus.in_valid = 0;
  endtask
  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(bus.out_valid), 1);
    check(tag, 32'(bus.out_y), 32'(exp));
    bus.out_ready = 1;
    step();
    bus.out_ready = 0;
  endtask
  initial begin
    bus.in_valid = 0;
    bus.out_ready = 0;
    bus.y = 0;
    bus.opcode = 0;
    bus.b = 4'd1;
    step();
    rst = 0;
    check("rst_count", 32'(bus.count), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    push(8'h0C, 3'd0, 4'd1);
    check("first_valid", 32'(bus.out_valid), 1);
    check("first_y", 32'(bus.out_y), 32'h0C);
    check("first_zero", 32'(bus.out_zero), 0);
    pop_check("first_pop", 8'h0C);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) push(8'(16 * r + k + 1), 3'd1, 4'd1);
      for (int k = 0; k < 3; k++) pop_check("wrap", 8'(16 * r + k + 1));
    end
    check("wrap_empty", 32'(bus.out_valid), 0);
    for (int k = 1; k <= 4; k++) push(8'(k), 3'd2, 4'd1);
    check("full_count", 32'(bus.count), 4);
    check("full_in_ready", 32'(bus.in_ready), 0);
    push(8'd5, 3'd2, 4'd1);
    check("full_drop_count", 32'(bus.count), 4);
    for (int k = 1; k <= 4; k++) pop_check("full_drain", 8'(k));
    check("drained_valid", 32'(bus.out_valid), 0);
    push(8'd20, 3'd0, 4'd1);
    push(8'd21, 3'd0, 4'd1);
    q = '{8'd20, 8'd21};
    bus.in_valid = 1;
    bus.out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      check("pp_head", 32'(bus.out_y), 32'(q[0]));
      bus.y = 8'(22 + k);
      step();
      void'(q.pop_front());
      q.push_back(8'(22 + k));
      check("pp_count", 32'(bus.count), 2);
    end
    bus.in_valid = 0;
    bus.out_ready = 0;
    pop_check("pp_drain", 8'd25);
    pop_check("pp_drain", 8'd26);
    for (int k = 0; k < 4; k++) push(8'(30 + k), 3'd0, 4'd1);
    bus.y = 8'd34;
    bus.in_valid = 1;
    bus.out_ready = 1;
    step();
    bus.in_valid = 0;
    bus.out_ready = 0;
    check("fullpp_count", 32'(bus.count), 3);
    for (int k = 1; k < 4; k++) pop_check("fullpp_drain", 8'(30 + k));
    check("fullpp_empty", 32'(bus.out_valid), 0);
    push(8'd7, 3'd3, 4'd0);
    check("dz_set", 32'(bus.out_dz), 1);
    check("dz_zero", 32'(bus.out_zero), 0);
    pop_check("dz_pop", 8'd7);
    push(8'd3, 3'd3, 4'd2);
    check("dz_clear", 32'(bus.out_dz), 0);
    pop_check("dz2_pop", 8'd3);
    push(8'd0, 3'd5, 4'd0);
    check("zero_set", 32'(bus.out_zero), 1);
    check("zero_dz", 32'(bus.out_dz), 0);
    check("zero_opcode", 32'(bus.out_opcode), 5);
    pop_check("zero_pop", 8'd0);
    for (int k = 0; k < 3; k++) push(8'(40 + k), 3'd0, 4'd1);
    check("pre_rst_count", 32'(bus.count), 3);
    bus.y = 8'd50;
    bus.in_valid = 1;
    bus.out_ready = 1;
    rst = 1;
    step();
    rst = 0;
    bus.in_valid = 0;
    bus.out_ready = 0;
    check("midrst_count", 32'(bus.count), 0);
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_in_ready", 32'(bus.in_ready), 1);
    push(8'd60, 3'd0, 4'd1);
    pop_check("post_rst", 8'd60);
`ifdef ALU_RESULT_STATS_EN
    rst = 1;
    step();
    rst = 0;
    check("stat_total_rst", 32'(stat_total), 0);
    check("stat_dz_rst", 32'(stat_dz), 0);
    check("stat_stall_rst", 32'(stat_full_stall), 0);
    for (int k = 0; k < 300; k++) begin
      push(8'(k), 3'd0, 4'd1);
      pop_check("stat_pp", 8'(k));
    end
    check("stat_total_sat", 32'(stat_total), 255);
    check("stat_dz_none", 32'(stat_dz), 0);
    push(8'd1, 3'd3, 4'd0);
    push(8'd2, 3'd3, 4'd0);
    check("stat_dz_two", 32'(stat_dz), 2);
    push(8'd3, 3'd0, 4'd1);
    push(8'd4, 3'd0, 4'd1);
    check("stat_stall_none", 32'(stat_full_stall), 0);
    bus.in_valid = 1;
    for (int k = 0; k < 3; k++) step();
    bus.in_valid = 0;
    check("stat_stall_three", 32'(stat_full_stall), 3);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
